// File: rtl/sim_watchdog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sim_watchdog_pkg
//  Description : Shared harness definitions for the simulation watchdog:
//                FSM state encoding, fail-code values and a state-to-code
//                decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sim_watchdog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_PASS       = 3'd2,
        ST_FAIL_TOTAL = 3'd3,
        ST_FAIL_STALL = 3'd4
    } wd_state_e;

    localparam logic [1:0] FAIL_NONE  = 2'b00;
    localparam logic [1:0] FAIL_TOTAL = 2'b01;
    localparam logic [1:0] FAIL_STALL = 2'b10;

    function automatic logic [1:0] fail_code_of(input wd_state_e st);
        case (st)
            ST_FAIL_TOTAL: fail_code_of = FAIL_TOTAL;
            ST_FAIL_STALL: fail_code_of = FAIL_STALL;
            default:       fail_code_of = FAIL_NONE;
        endcase
    endfunction

endpackage : sim_watchdog_pkg
`default_nettype wire

// File: rtl/sim_watchdog_stall_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sim_watchdog_stall_ctr
//  Description : Saturating up-counter with synchronous clear, asynchronous
//                active-low reset and a terminal-match flag.
//  Ports       : clock    - clock
//                reset_n  - asynchronous active-low reset
//                i_clear  - synchronous zero (wins over i_inc)
//                i_inc    - increment by one, saturating at all-ones
//                i_limit  - terminal limit, 0 disables the match
//                o_count  - current count
//                o_term   - count equals i_limit-1 and i_limit is non-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_watchdog_stall_ctr #(
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (i_limit != '0) && (r_count == (i_limit - WIDTH'(1)));

endmodule : sim_watchdog_stall_ctr
`default_nettype wire

// File: rtl/sim_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : sim_watchdog
//  Description : Simulation-harness watchdog. Arms on start, then ends the
//                run with a sticky registered verdict: software success,
//                global cycle timeout or accelerator stall timeout.
//  Ports       : clock, reset_n           - clock, async active-low reset
//                max_cycles, stall_limit  - limits, latched on start (0 = off)
//                start, progress, success - arm / forward-progress / pass
//                clear                    - synchronous return to IDLE
//                running, done, pass      - registered status
//                fail_code                - 00 none, 01 total, 10 stall
//                cycle_count, stall_count - RUN cycles / cycles since progress
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_watchdog
    import sim_watchdog_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int STALL_WIDTH = 20
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [CNT_WIDTH-1:0]   max_cycles,
    input  logic [STALL_WIDTH-1:0] stall_limit,
    input  logic                   start,
    input  logic                   progress,
    input  logic                   success,
    input  logic                   clear,
    output logic                   running,
    output logic                   done,
    output logic                   pass,
    output logic [1:0]             fail_code,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [STALL_WIDTH-1:0] stall_count
);

    wd_state_e              r_state;
    wd_state_e              w_next;
    logic [CNT_WIDTH-1:0]   r_max_q;
    logic [STALL_WIDTH-1:0] r_stall_q;
    logic [CNT_WIDTH-1:0]   r_cycle;
    logic                   r_running;
    logic                   r_done;
    logic                   r_pass;
    logic [1:0]             r_fail_code;

    logic w_arm;
    logic w_stay_run;
    logic w_total_hit;
    logic w_stall_term;
    logic w_stall_hit;
    logic w_stall_clr;
    logic w_stall_inc;

    assign w_total_hit = (r_max_q != '0) && (r_cycle == (r_max_q - CNT_WIDTH'(1)));
    // Progress in the would-be stall cycle rescues the run.
    assign w_stall_hit = w_stall_term && !progress;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !clear) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (clear)            w_next = ST_IDLE;
                else if (success)     w_next = ST_PASS;
                else if (w_total_hit) w_next = ST_FAIL_TOTAL;
                else if (w_stall_hit) w_next = ST_FAIL_STALL;
            end
            default: begin
                if (clear) w_next = ST_IDLE;
            end
        endcase
    end

    assign w_arm      = (r_state == ST_IDLE) && start && !clear;
    // Counters advance only while the run continues, so a verdict freezes
    // them at the value seen in the deciding cycle.
    assign w_stay_run = (r_state == ST_RUN) && (w_next == ST_RUN);

    assign w_stall_clr = clear || w_arm || (w_stay_run && progress);
    assign w_stall_inc = w_stay_run && !progress;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_max_q     <= '0;
            r_stall_q   <= '0;
            r_cycle     <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= FAIL_NONE;
        end else begin
            r_state <= w_next;
            if (w_arm) begin
                r_max_q   <= max_cycles;
                r_stall_q <= stall_limit;
            end
            if (clear || w_arm) begin
                r_cycle <= '0;
            end else if (w_stay_run) begin
                r_cycle <= r_cycle + CNT_WIDTH'(1);
            end
            // Outputs decoded from the next state keep them registered yet
            // aligned with r_state.
            r_running   <= (w_next == ST_RUN);
            r_pass      <= (w_next == ST_PASS);
            r_fail_code <= fail_code_of(w_next);
            r_done      <= (w_next == ST_PASS) || (w_next == ST_FAIL_TOTAL) ||
                           (w_next == ST_FAIL_STALL);
        end
    end

    sim_watchdog_stall_ctr #(
        .WIDTH (STALL_WIDTH)
    ) u_stall_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_stall_clr),
        .i_inc   (w_stall_inc),
        .i_limit (r_stall_q),
        .o_count (stall_count),
        .o_term  (w_stall_term)
    );

    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail_code;
    assign cycle_count = r_cycle;

endmodule : sim_watchdog
`default_nettype wire
